range_scan: RTL



---
 rtl/range_pkg.sv | 17 +
 rtl/max_sum_acc.sv | 61 ++++++
 rtl/range_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/range_pkg.sv
// Shared definitions for the Collatz range block and its scan sequencer.
package range_pkg;

  localparam int RAM_WORDS_DEFAULT     = 16;
  localparam int RAM_ADDR_BITS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_WAIT,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/max_sum_acc.sv
// Running maximum / argmax / sum over a stream of (index, count) words.
module max_sum_acc #(
  parameter int IDX_BITS = 4,
  parameter int CNT_BITS = 16,
  parameter int SUM_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                valid_i,
  input  logic [IDX_BITS-1:0] idx_i,
  input  logic [CNT_BITS-1:0] count_i,
  input  logic [31:0]         base_i,
  output logic [CNT_BITS-1:0] max_o,
  output logic [31:0]         argmax_o,
  output logic [SUM_BITS-1:0] sum_o
);

  logic [CNT_BITS-1:0] max_q, max_d;
  logic [31:0]         arg_q, arg_d;
  logic [SUM_BITS-1:0] sum_q, sum_d;
  logic                take;

  // Word 0 always loads, so an all-zero RAM still reports base as the argmax;
  // later words need a strictly larger count, keeping the lowest index on ties.
  assign take = valid_i && ((idx_i == '0) || (count_i > max_q));

  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    sum_d = sum_q;
    if (clr_i) begin
      max_d = '0;
      arg_d = '0;
      sum_d = '0;
    end else if (valid_i) begin
      sum_d = sum_q + SUM_BITS'(count_i);
      if (take) begin
        max_d = count_i;
        arg_d = base_i + 32'(idx_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      arg_q <= '0;
      sum_q <= '0;
    end else begin
      max_q <= max_d;
      arg_q <= arg_d;
      sum_q <= sum_d;
    end
  end

  assign max_o    = max_q;
  assign argmax_o = arg_q;
  assign sum_o    = sum_q;

endmodule

// File: rtl/range_scan.sv
// Launches one Collatz range run, waits for its RAM to fill, then sweeps the
// RAM through the range read port accumulating max, argmax and sum.
module range_scan
  import range_pkg::*;
#(
  parameter int RAM_WORDS     = RAM_WORDS_DEFAULT,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic [31:0]               base,
  output logic                      busy,
  output logic                      range_go,
  output logic [31:0]               range_start,
  input  logic                      range_done,
  input  logic [15:0]               range_count,
  output logic                      result_valid,
  output logic [15:0]               max_count,
  output logic [31:0]               max_n,
  output logic [16+RAM_ADDR_BITS-1:0] sum_count
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  scan_state_t              state_q, state_d;
  logic [31:0]              base_q, base_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [RAM_ADDR_BITS-1:0] idx_inc;
  logic                     busy_q, busy_d;
  logic                     go_q, go_d;
  logic [31:0]              start_q, start_d;
  logic                     valid_q, valid_d;

  logic                     acc_clr;
  logic                     acc_valid;
  logic [RAM_ADDR_BITS-1:0] acc_idx;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    go_d    = 1'b0;
    start_d = start_q;
    valid_d = valid_q;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          base_d  = base;
          valid_d = 1'b0;
          acc_clr = 1'b1;
          start_d = base;
          go_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_SETTLE;
      // range_done may still be left over from the previous run here.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (range_done) begin
          start_d = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_inc;
          start_d = 32'(idx_inc);
        end
      end
      ST_DRAIN: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The read port lags one cycle, so each cycle processes the previous address.
  always_comb begin
    acc_valid = (state_q == ST_DRAIN) || ((state_q == ST_SCAN) && (idx_q != '0));
    acc_idx   = (state_q == ST_DRAIN) ? LAST_IDX : (idx_q - 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      start_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      start_q <= start_d;
      valid_q <= valid_d;
    end
  end

  max_sum_acc #(
    .IDX_BITS (RAM_ADDR_BITS),
    .CNT_BITS (16),
    .SUM_BITS (16 + RAM_ADDR_BITS)
  ) u_acc (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (acc_clr),
    .valid_i  (acc_valid),
    .idx_i    (acc_idx),
    .count_i  (range_count),
    .base_i   (base_q),
    .max_o    (max_count),
    .argmax_o (max_n),
    .sum_o    (sum_count)
  );

  assign busy         = busy_q;
  assign range_go     = go_q;
  assign range_start  = start_q;
  assign result_valid = valid_q;

endmodule
